// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with the HI/LO register pair.
// Accepted mult/div ops compute their 64-bit result on the accept edge, hold it,
// and commit it to {hi,lo} when the busy countdown expires. mthi/mtlo write immediately.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are built only when
// the macro MDU_MADD_EN is defined; otherwise ops 7-10 are ignored like reserved ops.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    // architectural state
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [3:0]  r_cnt;    // remaining busy cycles
    logic [63:0] r_res;    // result (or product to accumulate) held until completion
    logic        r_wr;     // completion commits r_res; cleared for divide by zero
`ifdef MDU_MADD_EN
    logic        r_acc;    // completion accumulates into {hi,lo}
    logic        r_sub;    // accumulate subtracts instead of adds
`endif

    // decode
    logic        w_legal;
    logic        w_mul_s;  // signed product needed
    logic        w_mul;    // any multiply-class op
    logic        w_div;    // div or divu
    logic        w_div_s;  // signed divide
    logic        w_accept;
`ifdef MDU_MADD_EN
    logic        w_acc;
    logic        w_sub;
`endif

    // datapath
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic        w_q_neg;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;
    logic [63:0] w_final;

    assign busy  = (r_cnt != 4'd0);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = rd_sel ? r_hi : r_lo;

    // op decode: legality and operation class
    always_comb begin
        w_legal = 1'b0;
        w_mul_s = 1'b0;
        w_mul   = 1'b0;
        w_div   = 1'b0;
        w_div_s = 1'b0;
`ifdef MDU_MADD_EN
        w_acc   = 1'b0;
        w_sub   = 1'b0;
`endif
        case (op)
            OP_MULT:  begin w_legal = 1'b1; w_mul = 1'b1; w_mul_s = 1'b1; end
            OP_MULTU: begin w_legal = 1'b1; w_mul = 1'b1; end
            OP_DIV:   begin w_legal = 1'b1; w_div = 1'b1; w_div_s = 1'b1; end
            OP_DIVU:  begin w_legal = 1'b1; w_div = 1'b1; end
            OP_MTHI:  w_legal = 1'b1;
            OP_MTLO:  w_legal = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin w_legal = 1'b1; w_mul = 1'b1; w_mul_s = 1'b1; w_acc = 1'b1; end
            OP_MADDU: begin w_legal = 1'b1; w_mul = 1'b1; w_acc = 1'b1; end
            OP_MSUB:  begin w_legal = 1'b1; w_mul = 1'b1; w_mul_s = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
            OP_MSUBU: begin w_legal = 1'b1; w_mul = 1'b1; w_acc = 1'b1; w_sub = 1'b1; end
`endif
            default:  w_legal = 1'b0;
        endcase
    end

    assign w_accept = start && !busy && w_legal;

    // Products: a signed 32x32 product equals the low 64 bits of the
    // sign-extended 64x64 product, so one multiplier shape serves both.
    assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_prod   = w_mul_s ? w_prod_s : w_prod_u;

    // Division on magnitudes, with signs restored afterwards. The overflow case
    // 0x80000000 / -1 falls out naturally: |a| = 0x80000000, |b| = 1, quotient
    // sign positive, giving lo = 0x80000000 and hi = 0.
    assign w_abs_a    = a[31] ? (32'd0 - a) : a;
    assign w_abs_b    = b[31] ? (32'd0 - b) : b;
    assign w_dvd      = w_div_s ? w_abs_a : a;
    assign w_div_zero = (b == 32'd0);
    // divisor forced to 1 on zero so the divider never sees x/0; result is discarded
    assign w_dvs      = w_div_zero ? 32'd1 : (w_div_s ? w_abs_b : b);
    assign w_uq       = w_dvd / w_dvs;
    assign w_ur       = w_dvd % w_dvs;
    assign w_q_neg    = w_div_s && (a[31] ^ b[31]);
    assign w_quo      = w_q_neg ? (32'd0 - w_uq) : w_uq;
    // remainder takes the sign of the dividend
    assign w_rem      = (w_div_s && a[31]) ? (32'd0 - w_ur) : w_ur;

    // value committed to {hi,lo} on the completion edge
`ifdef MDU_MADD_EN
    always_comb begin
        w_final = r_res;
        if (r_acc) begin
            if (r_sub) w_final = {r_hi, r_lo} - r_res;
            else       w_final = {r_hi, r_lo} + r_res;
        end
    end
`else
    assign w_final = r_res;
`endif

    // HI/LO, countdown and pending-result state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_cnt <= 4'd0;
            r_res <= 64'd0;
            r_wr  <= 1'b0;
`ifdef MDU_MADD_EN
            r_acc <= 1'b0;
            r_sub <= 1'b0;
`endif
        end else if (busy) begin
            // start is ignored here, including on the edge busy falls
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
                if (r_wr) begin
                    r_hi <= w_final[63:32];
                    r_lo <= w_final[31:0];
                end
                r_wr <= 1'b0;
            end
        end else if (w_accept) begin
            if (op == OP_MTHI) begin
                r_hi <= a;
            end else if (op == OP_MTLO) begin
                r_lo <= a;
            end else if (w_mul) begin
                r_res <= w_prod;
                r_wr  <= 1'b1;
                r_cnt <= MULT_N;
`ifdef MDU_MADD_EN
                r_acc <= w_acc;
                r_sub <= w_sub;
`endif
            end else if (w_div) begin
                r_res <= {w_rem, w_quo};
                r_wr  <= !w_div_zero;
                r_cnt <= DIV_N;
`ifdef MDU_MADD_EN
                r_acc <= 1'b0;
                r_sub <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo (default parameters 5/10).
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_sel;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int n;

    mdu_hilo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_sel (rd_sel),
        .rdata  (rdata),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one-cycle request, returns 1 time unit after the sampling edge
    task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        op    = 4'd0;
    endtask

    // count edges until busy drops, scrambling operands to prove they were latched
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            a = $urandom;
            b = $urandom;
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 4'd0;
        a      = 32'd0;
        b      = 32'd0;
        rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // mult -1 * 2 = -2
        do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        chk("mult_busy_now", {31'd0, busy}, 32'd1);
        count_busy(n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2 -> q=-3 r=-1
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // div 7 / -2 -> q=-3 r=1
        do_op(4'd3, 32'd7, 32'hFFFF_FFFE);
        count_busy(n);
        chk("div2_lo", lo, 32'hFFFF_FFFD);
        chk("div2_hi", hi, 32'd1);

        // divu 7 / 2 -> q=3 r=1
        do_op(4'd4, 32'd7, 32'd2);
        count_busy(n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // overflow case
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // mthi/mtlo then divide by zero leaves hi/lo alone
        do_op(4'd5, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234_5678);
        do_op(4'd6, 32'd0, 32'd0);
        chk("mtlo_lo", lo, 32'd0);
        do_op(4'd4, 32'd99, 32'd0);
        count_busy(n);
        chk("dz_cycles", 32'(n), 32'd10);
        chk("dz_hi", hi, 32'h1234_5678);
        chk("dz_lo", lo, 32'd0);
        rd_sel = 1'b1;
        #1;
        chk("rdata_hi", rdata, 32'h1234_5678);
        rd_sel = 1'b0;
        #1;
        chk("rdata_lo", rdata, 32'd0);

        // start while busy is ignored: mult 3*4, div request in busy cycle 2
        do_op(4'd1, 32'd3, 32'd4);
        tick();
        start = 1'b1;
        op    = 4'd3;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        op    = 4'd0;
        count_busy(n);
        chk("ign_rest_cycles", 32'(n), 32'd3);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd12);

        // back-to-back: mthi held through the falling edge is rejected, then accepted
        start = 1'b1;
        op    = 4'd1;
        a     = 32'd2;
        b     = 32'd3;
        tick();
        op = 4'd5;
        a  = 32'h0000_AAAA;
        n  = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_cycles", 32'(n), 32'd5);
        chk("b2b_hi_rejected", hi, 32'd0);
        chk("b2b_lo", lo, 32'd6);
        tick();
        start = 1'b0;
        op    = 4'd0;
        chk("b2b_hi_accepted", hi, 32'h0000_AAAA);

        // reset during a divide abandons it
        do_op(4'd3, 32'd50, 32'd7);
        repeat (3) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (15) tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        // op 0 and reserved op are ignored
        do_op(4'd6, 32'h0000_0055, 32'd0);
        do_op(4'd0, 32'd9, 32'd9);
        chk("op0_busy", {31'd0, busy}, 32'd0);
        do_op(4'd12, 32'd9, 32'd9);
        chk("op12_busy", {31'd0, busy}, 32'd0);
        chk("op12_lo", lo, 32'h0000_0055);
        chk("op12_hi", hi, 32'd0);

`ifdef MDU_MADD_EN
        do_op(4'd5, 32'd0, 32'd0);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0);
        do_op(4'd8, 32'd1, 32'd1);
        count_busy(n);
        chk("maddu_cycles", 32'(n), 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
        // {1,0} + (-1 * 1) = {0,FFFFFFFF}
        do_op(4'd7, 32'hFFFF_FFFF, 32'd1);
        count_busy(n);
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, 32'hFFFF_FFFF);
        // {0,FFFFFFFF} - 1 = {0,FFFFFFFE}
        do_op(4'd10, 32'd1, 32'd1);
        count_busy(n);
        chk("msubu_hi", hi, 32'd0);
        chk("msubu_lo", lo, 32'hFFFF_FFFE);
        // {0,FFFFFFFE} - (-2 * 1) = {1,0}
        do_op(4'd9, 32'hFFFF_FFFE, 32'd1);
        count_busy(n);
        chk("msub_hi", hi, 32'd1);
        chk("msub_lo", lo, 32'd0);
`else
        do_op(4'd8, 32'd1, 32'd1);
        chk("maddu_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) tick();
        chk("maddu_off_hi", hi, 32'd0);
        chk("maddu_off_lo", lo, 32'h0000_0055);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO register pair for the MIPS datapath.
- Sits beside the combinational ALU in the execute stage.
- The ALU immediate-build ops write a constant result in one cycle. This block takes operands, runs for several cycles, and exposes results through mfhi/mflo reads and busy-based stalls.
- The controller stalls any MDU instruction (including mfhi/mflo) while busy=1.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10: busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled on rising edge
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 reserved
- a  input  32  operand rs
- b  input  32  operand rt
- rd_sel  input  1  0 selects LO, 1 selects HI
- rdata  output  32  combinational read of selected register (mfhi/mflo)
- busy  output  1  high while an operation is in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, internal counter=0, pending result cleared. An operation in flight is abandoned and no write occurs.
- rdata = rd_sel ? hi : lo, combinational. Reading during busy returns the old value; stalling is the controller's job.
- Accept condition: start=1, busy=0 and op is a legal operation. Otherwise the edge is ignored and state is unchanged. This covers start while busy, op=0, reserved ops, and madd-family ops when the feature is off.
- mthi/mtlo: on the accepting edge, hi<=a (or lo<=a). No busy cycles.
- Mult/div accept: on edge k, compute the 64-bit result from a and b and hold it internally; counter<=N (MULT_CYCLES or DIV_CYCLES).
- busy = (counter!=0).
- Each edge with counter!=0 decrements the counter. On the edge where counter goes 1->0, {hi,lo}<=result.
- So busy is high for exactly N cycles after edge k, and the new hi/lo is visible in the first cycle with busy=0.
- mult: signed 32x32 to 64, hi=upper 32 bits, lo=lower 32 bits. multu: same, unsigned.
- div: signed. lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0): busy still runs DIV_CYCLES, but hi/lo are left unchanged at completion.
- Signed overflow case, a=0x80000000 and b=0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands a and b are sampled only on the accepting edge; later changes have no effect.
- Back-to-back: a start on the same edge that busy falls (counter 1->0) is rejected, because busy was 1 when sampled. The next cycle accepts.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 7-10 are legal and take MULT_CYCLES.
  - madd: {hi,lo}<={hi,lo}+signed(a*b).
  - maddu: {hi,lo}<={hi,lo}+unsigned(a*b).
  - msub and msubu: subtract instead of add.
  - All are 64-bit modulo arithmetic. The accumulate uses the {hi,lo} value at completion time, which equals the value at the accept edge because no writes can occur while busy.
- Undefined: ops 7-10 are treated as reserved and ignored. No accumulate adder is synthesized.

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7 b=2 -> lo=3, hi=1.
- mthi a=0x12345678 then divu b=0 -> busy 10 cycles, hi stays 0x12345678, lo stays 0. rdata with rd_sel=1 reads 0x12345678.
- Start mult, then assert start div at cycle 2 of busy -> ignored. Only the mult result is written, and busy falls after 5 cycles.
- Start div, assert rst_n=0 at busy cycle 4 -> busy, hi and lo go to 0 immediately. After release, no late write occurs.
- With MDU_MADD_EN defined: mthi 0, mtlo 0xFFFFFFFF, then maddu a=1 b=1 -> hi=1, lo=0. Without the macro, op 8 is ignored and busy stays 0.
